pong_ctrl: RTL and testbench

PONG_CTRL -- requirements
Module: pong_ctrl

---
 rtl/pong_pkg.sv | 34 +++
 rtl/pong_paddle.sv | 66 ++++++
 rtl/pong_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_pong_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong controller.
//   - state_t : game state encoding, also driven onto o_state
//   - *_DEF   : default playfield / object geometry and timing
//   - CNT_W   : width of the serve-delay frame counter
//   - centre(): top-left coordinate that centres an object of a given size
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int HRES_DEF       = 640;
    localparam int VRES_DEF       = 480;
    localparam int PAD_H_DEF      = 64;
    localparam int PAD_W_DEF      = 8;
    localparam int BALL_DEF       = 8;
    localparam int PAD_SPD_DEF    = 4;
    localparam int BALL_SPD_DEF   = 2;
    localparam int PAD1_X_DEF     = 16;
    localparam int PAD2_X_DEF     = 616;
    localparam int WIN_DEF        = 9;
    localparam int SERVE_WAIT_DEF = 60;

    localparam int CNT_W = 16;

    function automatic logic [9:0] centre(input int extent, input int size);
        return 10'((extent - size) / 2);
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: button synchronizers, up/down resolution and clamped movement.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   step           : single-cycle strobe; the paddle moves once when high
//   btn_up, btn_dn : raw asynchronous buttons
//   pad_y          : registered paddle top, 0 .. VRES-PAD_H
module pong_paddle
    import pong_pkg::*;
#(
    parameter int VRES    = VRES_DEF,
    parameter int PAD_H   = PAD_H_DEF,
    parameter int PAD_SPD = PAD_SPD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [9:0] pad_y
);

    localparam logic signed [11:0] Y_MAX = 12'(VRES - PAD_H);
    localparam logic signed [11:0] SPD   = 12'(PAD_SPD);
    localparam logic [9:0]         Y_RST = centre(VRES, PAD_H);

    logic up_p0, up_p1;
    logic dn_p0, dn_p1;

    // Extra sign/headroom bits let the step overshoot either end before clamping.
    function automatic logic [9:0] move_clamp(input logic [9:0] y,
                                              input logic       go_up,
                                              input logic       go_dn);
        logic signed [11:0] t;
        t = $signed({2'b00, y});
        if (go_up && !go_dn)
            t = t - SPD;
        else if (go_dn && !go_up)
            t = t + SPD;
        if (t < 12'sd0)
            t = 12'sd0;
        else if (t > Y_MAX)
            t = Y_MAX;
        return t[9:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_p0 <= 1'b0;
            up_p1 <= 1'b0;
            dn_p0 <= 1'b0;
            dn_p1 <= 1'b0;
        end else begin
            up_p0 <= btn_up;
            up_p1 <= up_p0;
            dn_p0 <= btn_dn;
            dn_p1 <= dn_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pad_y <= Y_RST;
        else if (step)
            pad_y <= move_clamp(pad_y, up_p1, dn_p1);
    end

endmodule

// File: rtl/pong_ctrl.sv
// Pong game controller. Game state advances once per frame tick (rising
// edge of i_frame); all outputs are registered.
//   i_clk, i_rst_n         : pixel clock, asynchronous active-low reset
//   i_frame                : vblank level, synchronous to i_clk
//   i_start                : start button (asynchronous)
//   i_p1_up/dn, i_p2_up/dn : paddle buttons (asynchronous)
//   o_ball_x, o_ball_y     : ball top-left
//   o_pad1_y, o_pad2_y     : paddle tops
//   o_score1, o_score2     : scores, saturating at WIN
//   o_state                : current game state (pong_pkg::state_t)
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int HRES       = HRES_DEF,
    parameter int VRES       = VRES_DEF,
    parameter int PAD_H      = PAD_H_DEF,
    parameter int PAD_W      = PAD_W_DEF,
    parameter int BALL       = BALL_DEF,
    parameter int PAD_SPD    = PAD_SPD_DEF,
    parameter int BALL_SPD   = BALL_SPD_DEF,
    parameter int PAD1_X     = PAD1_X_DEF,
    parameter int PAD2_X     = PAD2_X_DEF,
    parameter int WIN        = WIN_DEF,
    parameter int SERVE_WAIT = SERVE_WAIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame,
    input  logic       i_start,
    input  logic       i_p1_up,
    input  logic       i_p1_dn,
    input  logic       i_p2_up,
    input  logic       i_p2_dn,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic [9:0] o_pad1_y,
    output logic [9:0] o_pad2_y,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic [2:0] o_state
);

    localparam logic [9:0] BALL_X0   = centre(HRES, BALL);
    localparam logic [9:0] BALL_Y0   = centre(VRES, BALL);
    localparam logic [9:0] X_RIGHT   = 10'(HRES - BALL);
    localparam logic [9:0] Y_BOTTOM  = 10'(VRES - BALL);
    localparam logic [9:0] P1_BOUNCE = 10'(PAD1_X + PAD_W);
    localparam logic [9:0] P2_BOUNCE = 10'(PAD2_X - BALL);

    localparam logic signed [10:0] B_SPD   = 11'(BALL_SPD);
    localparam logic signed [10:0] Y_BOT_S = 11'(VRES - BALL);
    localparam logic signed [10:0] X_MAX_S = 11'(HRES - BALL);
    localparam logic signed [10:0] P1_EDGE = 11'(PAD1_X + PAD_W);
    localparam logic signed [10:0] P2_EDGE = 11'(PAD2_X - BALL);

    localparam logic [10:0]      BALL_U  = 11'(BALL);
    localparam logic [10:0]      PAD_H_U = 11'(PAD_H);
    localparam logic [3:0]       WIN_U   = 4'(WIN);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SERVE_WAIT - 1);

    logic frame_q, tick;
    logic start_p0, start_p1;

    state_t           state, state_nxt;
    logic [9:0]       ball_x, ball_x_nxt;
    logic [9:0]       ball_y, ball_y_nxt;
    logic             dx, dx_nxt;       // 1 = moving right (toward P2)
    logic             dy, dy_nxt;       // 1 = moving down
    logic [3:0]       score1, score1_nxt;
    logic [3:0]       score2, score2_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [9:0]         pad1_y, pad2_y;
    logic               pad_step;
    logic signed [10:0] nx, ny;
    logic               ovl1, ovl2, hit1, hit2;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_U) ? s : s + 4'd1;
    endfunction

    assign tick     = i_frame & ~frame_q;
    assign pad_step = tick && (state == ST_SERVE || state == ST_PLAY);

    // Vertical overlap of the ball's current row span with each paddle.
    assign ovl1 = (({1'b0, ball_y} + BALL_U) > {1'b0, pad1_y}) &&
                  ({1'b0, ball_y} < ({1'b0, pad1_y} + PAD_H_U));
    assign ovl2 = (({1'b0, ball_y} + BALL_U) > {1'b0, pad2_y}) &&
                  ({1'b0, ball_y} < ({1'b0, pad2_y} + PAD_H_U));

    pong_paddle #(
        .VRES    (VRES),
        .PAD_H   (PAD_H),
        .PAD_SPD (PAD_SPD)
    ) u_pad1 (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .step   (pad_step),
        .btn_up (i_p1_up),
        .btn_dn (i_p1_dn),
        .pad_y  (pad1_y)
    );

    pong_paddle #(
        .VRES    (VRES),
        .PAD_H   (PAD_H),
        .PAD_SPD (PAD_SPD)
    ) u_pad2 (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .step   (pad_step),
        .btn_up (i_p2_up),
        .btn_dn (i_p2_dn),
        .pad_y  (pad2_y)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_q  <= 1'b0;
            start_p0 <= 1'b0;
            start_p1 <= 1'b0;
        end else begin
            frame_q  <= i_frame;
            start_p0 <= i_start;
            start_p1 <= start_p0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            dx     <= 1'b1;
            dy     <= 1'b1;
            score1 <= 4'd0;
            score2 <= 4'd0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            ball_x <= ball_x_nxt;
            ball_y <= ball_y_nxt;
            dx     <= dx_nxt;
            dy     <= dy_nxt;
            score1 <= score1_nxt;
            score2 <= score2_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ball_x_nxt = ball_x;
        ball_y_nxt = ball_y;
        dx_nxt     = dx;
        dy_nxt     = dy;
        score1_nxt = score1;
        score2_nxt = score2;
        cnt_nxt    = cnt;

        nx   = dx ? $signed({1'b0, ball_x}) + B_SPD : $signed({1'b0, ball_x}) - B_SPD;
        ny   = dy ? $signed({1'b0, ball_y}) + B_SPD : $signed({1'b0, ball_y}) - B_SPD;
        hit1 = !dx && (nx <= P1_EDGE) && ovl1;
        hit2 =  dx && (nx >= P2_EDGE) && ovl2;

        if (tick) begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_p1) begin
                        state_nxt  = ST_SERVE;
                        score1_nxt = 4'd0;
                        score2_nxt = 4'd0;
                        ball_x_nxt = BALL_X0;
                        ball_y_nxt = BALL_Y0;
                        dx_nxt     = 1'b1;
                        dy_nxt     = 1'b1;
                        cnt_nxt    = '0;
                    end
                end

                ST_SERVE: begin
                    if (cnt == WAIT_LAST) begin
                        state_nxt = ST_PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (ny <= 11'sd0) begin
                        ball_y_nxt = 10'd0;
                        dy_nxt     = 1'b1;
                    end else if (ny >= Y_BOT_S) begin
                        ball_y_nxt = Y_BOTTOM;
                        dy_nxt     = 1'b0;
                    end else begin
                        ball_y_nxt = ny[9:0];
                    end

                    // A paddle hit takes priority over the ball leaving the field.
                    // On a miss dx is left alone: it still points at the player
                    // who conceded, which is where the next serve goes.
                    if (hit1) begin
                        ball_x_nxt = P1_BOUNCE;
                        dx_nxt     = 1'b1;
                    end else if (hit2) begin
                        ball_x_nxt = P2_BOUNCE;
                        dx_nxt     = 1'b0;
                    end else if (nx < 11'sd0) begin
                        ball_x_nxt = 10'd0;
                        score2_nxt = sat_inc(score2);
                        state_nxt  = ST_POINT;
                    end else if (nx > X_MAX_S) begin
                        ball_x_nxt = X_RIGHT;
                        score1_nxt = sat_inc(score1);
                        state_nxt  = ST_POINT;
                    end else begin
                        ball_x_nxt = nx[9:0];
                    end
                end

                ST_POINT: begin
                    if (score1 == WIN_U || score2 == WIN_U) begin
                        state_nxt = ST_OVER;
                    end else begin
                        state_nxt  = ST_SERVE;
                        ball_x_nxt = BALL_X0;
                        ball_y_nxt = BALL_Y0;
                        dy_nxt     = ~dy;
                        cnt_nxt    = '0;
                    end
                end

                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_ball_x = ball_x;
    assign o_ball_y = ball_y;
    assign o_pad1_y = pad1_y;
    assign o_pad2_y = pad2_y;
    assign o_score1 = score1;
    assign o_score2 = score2;
    assign o_state  = state;

endmodule

// File: tb/tb_pong_ctrl.sv
// Testbench for pong_ctrl: a frame-level game model runs alongside the DUT
// and every tick's registered outputs are compared with it.
module tb_pong_ctrl;

    localparam int HRES = 640, VRES = 480, PAD_H = 64, PAD_W = 8, BALL = 8;
    localparam int PAD_SPD = 4, BALL_SPD = 2, PAD1_X = 16, PAD2_X = 616;
    localparam int WIN = 9, SERVE_WAIT = 60;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

    logic       clk, rst_n, frame, start;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [9:0] ball_x, ball_y, pad1_y, pad2_y;
    logic [3:0] score1, score2;
    logic [2:0] state;
    logic [50:0] obs;

    int total, bad;

    // Model: positions, signed velocities in pixels/frame, scores, serve frames.
    int m_state, m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_s1, m_s2, m_wait;

    pong_ctrl dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_frame  (frame),
        .i_start  (start),
        .i_p1_up  (p1_up),
        .i_p1_dn  (p1_dn),
        .i_p2_up  (p2_up),
        .i_p2_dn  (p2_dn),
        .o_ball_x (ball_x),
        .o_ball_y (ball_y),
        .o_pad1_y (pad1_y),
        .o_pad2_y (pad2_y),
        .o_score1 (score1),
        .o_score2 (score2),
        .o_state  (state)
    );

    assign obs = {state, ball_x, ball_y, pad1_y, pad2_y, score1, score2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [50:0] expv();
        return {3'(m_state), 10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2)};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_bx = (HRES - BALL) / 2;  m_by = (VRES - BALL) / 2;
        m_vx = BALL_SPD;           m_vy = BALL_SPD;
        m_p1 = (VRES - PAD_H) / 2; m_p2 = (VRES - PAD_H) / 2;
        m_s1 = 0; m_s2 = 0; m_wait = 0;
    endtask

    task automatic model_step(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        int prev, nx, ny, oy;
        bit h1, h2;
        prev = m_state;
        case (m_state)
            M_IDLE, M_OVER: if (st) begin
                m_state = M_SERVE; m_s1 = 0; m_s2 = 0;
                m_bx = (HRES - BALL) / 2; m_by = (VRES - BALL) / 2;
                m_vx = BALL_SPD; m_vy = BALL_SPD; m_wait = 0;
            end
            M_SERVE: begin
                m_wait++;
                if (m_wait == SERVE_WAIT) begin m_state = M_PLAY; m_wait = 0; end
            end
            M_PLAY: begin
                oy = m_by; nx = m_bx + m_vx; ny = m_by + m_vy;
                if (ny <= 0) begin m_by = 0; m_vy = BALL_SPD; end
                else if (ny >= VRES - BALL) begin m_by = VRES - BALL; m_vy = -BALL_SPD; end
                else m_by = ny;
                h1 = (m_vx < 0) && (nx <= PAD1_X + PAD_W) && (oy + BALL > m_p1) && (oy < m_p1 + PAD_H);
                h2 = (m_vx > 0) && (nx >= PAD2_X - BALL) && (oy + BALL > m_p2) && (oy < m_p2 + PAD_H);
                if (h1) begin m_bx = PAD1_X + PAD_W; m_vx = BALL_SPD; end
                else if (h2) begin m_bx = PAD2_X - BALL; m_vx = -BALL_SPD; end
                else if (nx < 0) begin m_bx = 0; m_s2 = (m_s2 < WIN) ? m_s2 + 1 : WIN; m_state = M_POINT; end
                else if (nx > HRES - BALL) begin m_bx = HRES - BALL; m_s1 = (m_s1 < WIN) ? m_s1 + 1 : WIN; m_state = M_POINT; end
                else m_bx = nx;
            end
            M_POINT: begin
                if (m_s1 == WIN || m_s2 == WIN) m_state = M_OVER;
                else begin
                    m_state = M_SERVE; m_wait = 0; m_vy = -m_vy;
                    m_bx = (HRES - BALL) / 2; m_by = (VRES - BALL) / 2;
                end
            end
            default: ;
        endcase
        if (prev == M_SERVE || prev == M_PLAY) begin
            m_p1 = clampi(m_p1 + PAD_SPD * (int'(d1) - int'(u1)), 0, VRES - PAD_H);
            m_p2 = clampi(m_p2 + PAD_SPD * (int'(d2) - int'(u2)), 0, VRES - PAD_H);
        end
    endtask

    // Called just after a rising clock edge; returns just after the tick edge.
    task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; start = st;
        repeat (3) @(posedge clk);
        #1 frame = 1'b1;
        @(posedge clk);
        #1 frame = 1'b0;
        model_step(u1, d1, u2, d2, st);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame = 1'b0; start = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== expv()) begin
            bad++; $display("FAIL reset_values: got %h want %h", obs, expv());
        end
        rst_n = 1'b1;
        do_tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs !== expv()) begin
            bad++; $display("FAIL idle_no_move: got %h want %h", obs, expv());
        end
        total++;
        if (pad1_y !== 10'd208 || pad2_y !== 10'd208 || state !== 3'd0) begin
            bad++; $display("FAIL idle_hold: got pads %0d/%0d state %0d want 208/208 state 0", pad1_y, pad2_y, state);
        end
    endtask

    task automatic test_serve();
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({state, ball_x, ball_y, score1, score2} !== {3'd1, 10'd316, 10'd236, 4'd0, 4'd0}) begin
            bad++; $display("FAIL serve_entry: got state %0d ball %0d,%0d scores %0d/%0d want 1 316,236 0/0",
                            state, ball_x, ball_y, score1, score2);
        end
        for (int i = 1; i <= SERVE_WAIT; i++) begin
            do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (state !== ((i < SERVE_WAIT) ? 3'd1 : 3'd2) || obs !== expv()) begin
                bad++; $display("FAIL serve_wait tick %0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    task automatic test_paddle();
        int keep;
        keep = m_p1;
        for (int i = 0; i < 10; i++) begin
            do_tick(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'b1);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL paddle_both tick %0d: got %h want %h", i, obs, expv());
            end
        end
        total++;
        if (pad1_y !== 10'(keep)) begin
            bad++; $display("FAIL paddle_hold: got %0d want %0d", pad1_y, keep);
        end
        for (int i = 0; i < 60; i++) begin
            do_tick(1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom));
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL paddle_run tick %0d: got %h want %h", i, obs, expv());
            end
        end
        total++;
        if (pad1_y !== 10'd0 || pad2_y !== 10'd416) begin
            bad++; $display("FAIL paddle_clamp: got %0d/%0d want 0/416", pad1_y, pad2_y);
        end
    endtask

    task automatic test_game();
        bit u1, d1, u2, d2, chase;
        int bc, c1, c2;
        for (int k = 0; k < 12000 && m_state != M_OVER; k++) begin
            bc = m_by + BALL / 2; c1 = m_p1 + PAD_H / 2; c2 = m_p2 + PAD_H / 2;
            chase = ((k / 400) % 2) == 0;
            u1 = chase ? (bc < c1) : (bc >= c1);
            d1 = chase ? (bc > c1) : (bc < c1);
            u2 = (bc >= c2);
            d2 = (bc < c2);
            if ($urandom_range(0, 7) == 0) {u1, d1, u2, d2} = 4'($urandom);
            do_tick(u1, d1, u2, d2, $urandom_range(0, 3) == 0);
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL game tick %0d: got %h want %h", k, obs, expv());
            end
        end
        total++;
        if (m_state != M_OVER || state !== 3'd4) begin
            bad++; $display("FAIL game_over_reached: got state %0d want 4", state);
        end
    endtask

    task automatic test_over();
        logic [50:0] snap;
        snap = expv();
        for (int i = 0; i < 20; i++) begin
            do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            total++;
            if (obs !== snap) begin
                bad++; $display("FAIL over_freeze tick %0d: got %h want %h", i, obs, snap);
            end
        end
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({state, score1, score2} !== {3'd1, 4'd0, 4'd0} || obs !== expv()) begin
            bad++; $display("FAIL over_restart: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < SERVE_WAIT + 8; i++)
            do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        total++;
        if (state !== 3'd2 || obs !== expv()) begin
            bad++; $display("FAIL mid_play: got %h want %h", obs, expv());
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== expv()) begin
            bad++; $display("FAIL reset_async: got %h want %h", obs, expv());
        end
        frame = 1'b1; start = 1'b1; p1_dn = 1'b1; p2_up = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs !== expv()) begin
            bad++; $display("FAIL reset_hold: got %h want %h", obs, expv());
        end
        frame = 1'b0;
        rst_n = 1'b1;
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (state !== 3'd1 || obs !== expv()) begin
            bad++; $display("FAIL reset_release: got %h want %h", obs, expv());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_serve();
        test_paddle();
        test_game();
        test_over();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
